// File: rtl/seq_mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: controller states
// and the default operand width.
package seq_mul_pkg;

    localparam int SEQ_MUL_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } seq_mul_state_t;

endpackage

// File: rtl/seq_mul_datapath.sv
// Operand/accumulator registers for the repeated-addition multiplier.
// The controller sequences it through load, clear, add and decrement strobes.
module seq_mul_datapath
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = SEQ_MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_lda,
    input  logic               i_ldb,
    input  logic               i_clrp,
    input  logic               i_addp,
    input  logic               i_decb,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_bz
);

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_p;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_sum;
    logic [WIDTH-1:0]   w_b_dec;

    assign w_a_ext = {{WIDTH{1'b0}}, r_a};
    assign w_sum   = r_p + w_a_ext;
    assign w_b_dec = r_b - WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_p <= '0;
        end else begin
            if (i_lda) begin
                r_a <= i_data;
            end
            // Load wins over decrement; the two are never asserted together.
            if (i_ldb) begin
                r_b <= i_data;
            end else if (i_decb) begin
                r_b <= w_b_dec;
            end
            if (i_clrp) begin
                r_p <= '0;
            end else if (i_addp) begin
                r_p <= w_sum;
            end
        end
    end

    assign o_product = r_p;
    assign o_bz      = (r_b == '0);

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle multiplier: accepts A then B on a shared bus and accumulates
// A once per cycle while counting B down to zero, then pulses done.
//
// state  | meaning
// IDLE   | waiting for start; A captured and P cleared on the start cycle
// LOAD_B | capture B from data_in
// CALC   | P += A and B -= 1 while B != 0
// DONE   | one-cycle done pulse, product final
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = SEQ_MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    seq_mul_state_t r_state;
    logic           r_busy;
    logic           r_done;

    logic w_lda;
    logic w_ldb;
    logic w_clrp;
    logic w_addp;
    logic w_decb;
    logic w_bz;

    assign w_lda  = (r_state == IDLE) && start;
    assign w_clrp = w_lda;
    assign w_ldb  = (r_state == LOAD_B);
    assign w_addp = (r_state == CALC) && !w_bz;
    assign w_decb = w_addp;

    // busy/done are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD_B;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD_B: begin
                    r_state <= CALC;
                end
                CALC: begin
                    if (w_bz) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    seq_mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_data    (data_in),
        .i_lda     (w_lda),
        .i_ldb     (w_ldb),
        .i_clrp    (w_clrp),
        .i_addp    (w_addp),
        .i_decb    (w_decb),
        .o_product (product),
        .o_bz      (w_bz)
    );

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: a vector table of A/B/product/done-cycle
// plus hand-written sequences for ignored starts, held start and mid-op reset.
module tb_seq_multiplier;

    localparam int W = 5;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   data_in;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int n_pass;
    int n_total;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int exp_p;
        int exp_cyc;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered just after a rising edge with the DUT idle (cycle 0).
    // Returns just after the rising edge two cycles past the done cycle.
    task automatic run_op(input string name, input int a, input int b,
                          input int exp_p, input int exp_cyc);
        int c;
        int done_cyc;
        int busy_ok;
        start   = 1'b1;
        data_in = W'(a);
        @(posedge clk); #1;
        start    = 1'b0;
        data_in  = W'(b);
        c        = 1;
        done_cyc = -1;
        busy_ok  = 1;
        while (c <= 80) begin
            @(negedge clk);
            if (!busy) busy_ok = 0;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
            data_in = W'($urandom_range(0, 31));
            c++;
        end
        check({name, " done_cycle"}, done_cyc, exp_cyc);
        check({name, " product"}, int'(product), exp_p);
        check({name, " busy_while_active"}, busy_ok, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, " idle_after"}, {30'd0, busy, done}, 0);
        check({name, " product_hold"}, int'(product), exp_p);
        @(posedge clk); #1;
    endtask

    vec_t vecs[7];
    int   sched_st[17];
    int   sched_din[17];
    int   n_done;

    initial begin
        n_pass  = 0;
        n_total = 0;
        vecs[0] = '{a: 5,  b: 3,  exp_p: 15,  exp_cyc: 6};
        vecs[1] = '{a: 31, b: 31, exp_p: 961, exp_cyc: 34};
        vecs[2] = '{a: 7,  b: 0,  exp_p: 0,   exp_cyc: 3};
        vecs[3] = '{a: 0,  b: 9,  exp_p: 0,   exp_cyc: 12};
        vecs[4] = '{a: 1,  b: 1,  exp_p: 1,   exp_cyc: 4};
        vecs[5] = '{a: 31, b: 1,  exp_p: 31,  exp_cyc: 4};
        vecs[6] = '{a: 12, b: 13, exp_p: 156, exp_cyc: 16};

        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset product", int'(product), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].exp_p, vecs[i].exp_cyc);
        end

        // Starts while busy (cycles 2, 5, DONE cycle 9) must be ignored.
        for (int c = 0; c < 17; c++) begin
            sched_st[c]  = 0;
            sched_din[c] = 0;
        end
        sched_st[0] = 1;  sched_din[0] = 4;
        sched_din[1] = 6;
        sched_st[2] = 1;  sched_din[2] = 9;
        sched_st[5] = 1;  sched_din[5] = 13;
        sched_st[9] = 1;  sched_din[9] = 7;
        sched_st[10] = 1; sched_din[10] = 2;
        sched_din[11] = 2;
        n_done = 0;
        for (int c = 0; c < 17; c++) begin
            start   = sched_st[c][0];
            data_in = W'(sched_din[c]);
            @(negedge clk);
            if (done) n_done++;
            if (c == 9) begin
                check("ignore done@9", int'(done), 1);
                check("ignore product@9", int'(product), 24);
            end
            if (c == 10) check("ignore idle@10", int'(busy), 0);
            if (c == 15) begin
                check("restart done@15", int'(done), 1);
                check("restart product@15", int'(product), 4);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("ignore done_count", n_done, 2);

        // Start held high: a new op begins as soon as IDLE is re-entered.
        n_done = 0;
        for (int c = 0; c < 13; c++) begin
            start   = 1'b1;
            data_in = (c < 7) ? W'(3) : W'(2);
            @(negedge clk);
            if (done) n_done++;
            if (c == 6) begin
                check("held done@6", int'(done), 1);
                check("held product@6", int'(product), 9);
            end
            if (c == 12) begin
                check("held done@12", int'(done), 1);
                check("held product@12", int'(product), 4);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("held done_count", n_done, 2);
        @(posedge clk); #1;

        // Reset in cycle 5 abandons the operation.
        start   = 1'b1;
        data_in = W'(6);
        @(posedge clk); #1;
        start   = 1'b0;
        data_in = W'(10);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset busy", int'(busy), 0);
        check("midreset product", int'(product), 0);
        check("midreset done", int'(done), 0);
        n_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("midreset quiet", n_done, 0);
        @(posedge clk); #1;
        run_op("after_reset", 3, 3, 9, 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Repeated-addition multiplier; the inverse companion to the repeated-subtraction divider datapath.
- Operands arrive on a shared `data_in` bus on two consecutive cycles: multiplicand A first, then multiplier B.
- Accumulates P = A*B by adding A once per cycle while decrementing B to zero.
- Reports completion with a one-cycle `done` pulse. Sits beside the divider as the arithmetic unit for multi-cycle multiply.

Parameters:
- WIDTH, 5, operand width in bits. The product is 2*WIDTH bits wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE. `data_in` carries A in the same cycle.
- data_in  input  WIDTH  operand bus: A in the start cycle, B in the following cycle.
- product  output  2*WIDTH  accumulator P; final value valid from the `done` cycle until the next accepted start.
- busy  output  1  high in LOAD_B, CALC and DONE; low in IDLE.
- done  output  1  one-cycle pulse when product is final.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; A=0, B=0, P=0; busy=0, done=0.
  - Applies in any state. A reset mid-operation abandons the operation with no `done` pulse.
- States: IDLE, LOAD_B, CALC, DONE. Registered FSM; outputs decoded from state (Moore).
- IDLE:
  - start=1: A<=data_in, P<=0, go to LOAD_B.
  - start=0: hold all registers; product keeps the last result.
- LOAD_B: B<=data_in unconditionally, go to CALC. `start` is ignored.
- CALC:
  - B!=0: P<=P+A (A zero-extended to 2*WIDTH), B<=B-1, stay in CALC.
  - B==0: no add, go to DONE.
- DONE: done=1 for exactly this cycle, go to IDLE. `start` is ignored in this cycle.
- Latency:
  - Start accepted in cycle 0 → `done` high in cycle B+3.
  - Next start can be accepted in cycle B+4.
- Width and arithmetic:
  - Maximum product (2^WIDTH-1)^2 < 2^(2*WIDTH), so the accumulator never overflows.
  - B decrement never wraps, because the decrement is gated by B!=0.
- Boundaries:
  - B=0 → `done` in cycle 3, product=0.
  - A=0 → B iterations of +0, product=0.
  - start held high continuously → a new operation begins each time IDLE is re-entered. A is captured from `data_in` in that IDLE cycle.
  - `start` while busy → ignored, with no queuing.

Decomposition:
- Shared package seq_mul_pkg:
  - state enum (IDLE=2'd0, LOAD_B=2'd1, CALC=2'd2, DONE=2'd3);
  - default WIDTH constant.
- One sub-module, seq_mul_datapath:
  - contains the A/B/P registers, the 2*WIDTH adder, the B decrementer and the B==0 detect (`bz` flag);
  - control inputs: lda, ldb, clrp, addp, decb.
- Top level seq_multiplier holds the controller FSM and drives those controls.

Test Plan:
- Reset, then start with data_in=5, next cycle data_in=3 → `done` in cycle 6, product=15, busy high in cycles 1-6.
- A=31, B=31 → `done` in cycle 34, product=961 (0x3C1); no overflow.
- A=7, B=0 → `done` in cycle 3, product=0. A=0, B=9 → `done` in cycle 12, product=0.
- Start with A=4, B=6; pulse start again in cycles 2, 5 and the DONE cycle → all ignored, product=24. A new start in cycle 10 with A=2, B=2 → product=4, `done` in cycle 15.
- Start A=6, B=10; assert rst_n=0 in cycle 5 → next cycle state=IDLE, product=0, busy=0, no `done`. Restart with A=3, B=3 → product=9.
